// File: rtl/control_pkg.sv
// Shared control-word layout, phase encoding and NOP word for the sequencer
// and every decoder that produces control words.
package control_pkg;

  localparam int CW_W       = 33;
  localparam int INSTR_W    = 32;
  localparam int STATUS_W   = 5;
  localparam int STATE_W    = 2;
  localparam int WD_W       = 3;

  localparam int CW_ALU_EN    = 32;
  localparam int CW_ALU_BS    = 31;
  localparam int CW_ALU_FS_HI = 30;
  localparam int CW_ALU_FS_LO = 26;
  localparam int CW_RF_B_EN   = 25;
  localparam int CW_RF_SA_HI  = 24;
  localparam int CW_RF_SA_LO  = 20;
  localparam int CW_RF_SB_HI  = 19;
  localparam int CW_RF_SB_LO  = 15;
  localparam int CW_RF_DA_HI  = 14;
  localparam int CW_RF_DA_LO  = 10;
  localparam int CW_RF_W      = 9;
  localparam int CW_RAM_EN    = 8;
  localparam int CW_RAM_W     = 7;
  localparam int CW_PC_EN     = 6;
  localparam int CW_PC_FS_HI  = 5;
  localparam int CW_PC_FS_LO  = 4;
  localparam int CW_PC_IS     = 3;
  localparam int CW_STATUS_LD = 2;
  localparam int CW_NS_HI     = 1;
  localparam int CW_NS_LO     = 0;

  localparam logic [CW_W-1:0] CW_NOP = '0;

  // Bits that commit architectural state; cleared while the datapath stalls.
  localparam logic [CW_W-1:0] CW_WRITE_MASK =
    (CW_W'(1) << CW_RF_W) | (CW_W'(1) << CW_RAM_W) |
    (CW_W'(1) << CW_PC_EN) | (CW_W'(1) << CW_STATUS_LD);

  localparam logic [STATE_W-1:0] NS_RETIRE = '0;
  localparam logic [WD_W-1:0]    WD_MAX    = '1;

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_t;

endpackage

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter; wraps naturally at 2^32.
module retire_counter
  import control_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                inc,
  output logic [INSTR_W-1:0]  count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Two-phase fetch/execute sequencer: holds the instruction register and
// decoder sub-state, gates the control word, and guards against runaway EXEC.
module control_sequencer
  import control_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fetch_valid,
  input  logic [INSTR_W-1:0]   instr_in,
  input  logic                 stall,
  input  logic [STATUS_W-1:0]  status_in,
  input  logic [CW_W-1:0]      cw_in,
  output logic                 fetch_req,
  output logic [INSTR_W-1:0]   I,
  output logic [STATE_W-1:0]   state,
  output logic [STATUS_W-1:0]  status,
  output logic [CW_W-1:0]      cw_out,
  output logic [INSTR_W-1:0]   instr_count,
  output logic                 seq_error
);

  phase_t          phase, phase_nxt;
  logic [WD_W-1:0] wd, wd_nxt;
  logic            latch, retire, timeout, advance, ld_status;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) phase <= PH_FETCH;
    else        phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    wd_nxt    = wd;
    fetch_req = 1'b0;
    cw_out    = CW_NOP;
    latch     = 1'b0;
    retire    = 1'b0;
    timeout   = 1'b0;
    advance   = 1'b0;
    ld_status = 1'b0;
    case (phase)
      PH_FETCH: begin
        fetch_req = 1'b1;
        if (!stall && fetch_valid) begin
          latch     = 1'b1;
          wd_nxt    = '0;
          phase_nxt = PH_EXEC;
        end
      end
      PH_EXEC: begin
        cw_out = stall ? (cw_in & ~CW_WRITE_MASK) : cw_in;
        if (!stall) begin
          ld_status = cw_in[CW_STATUS_LD];
          if (cw_in[CW_NS_HI:CW_NS_LO] == NS_RETIRE) begin
            retire    = 1'b1;
            wd_nxt    = '0;
            phase_nxt = PH_FETCH;
          end else if (wd == WD_MAX) begin
            // Eighth non-retiring cycle: abandon the instruction, no retirement.
            timeout   = 1'b1;
            wd_nxt    = '0;
            phase_nxt = PH_FETCH;
          end else begin
            advance = 1'b1;
            wd_nxt  = wd + 1'b1;
          end
        end
      end
      default: phase_nxt = PH_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      I         <= '0;
      state     <= '0;
      status    <= '0;
      wd        <= '0;
      seq_error <= 1'b0;
    end else begin
      wd <= wd_nxt;
      if (latch) begin
        I     <= instr_in;
        state <= '0;
      end
      if (advance)   state     <= cw_in[CW_NS_HI:CW_NS_LO];
      if (ld_status) status    <= status_in;
      if (timeout)   seq_error <= 1'b1;
    end
  end

  retire_counter u_retire (
    .clock (clock),
    .reset (reset),
    .inc   (retire),
    .count (instr_count)
  );

endmodule
